// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART: FSM encodings, parity selectors,
// oversampling indices and the baud divisor calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    localparam int         OS_RATE     = 16;
    localparam logic [3:0] OS_SAMPLE_A = 4'd7;
    localparam logic [3:0] OS_SAMPLE_B = 4'd8;
    localparam logic [3:0] OS_SAMPLE_C = 4'd9;
    localparam logic [3:0] OS_LAST     = 4'd15;

    // System clocks per oversampling tick, truncated.
    function automatic int calc_div(input int clk_mhz, input int baud);
        return (clk_mhz * 1000000) / (baud * OS_RATE);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversampling tick generator: one-cycle pulse every DIV clocks while enabled,
// counter parked at zero while disabled so each frame starts phase-aligned.
module uart_os_tick #(
    parameter int DIV = 27
) (
    input  logic i_clk_sys,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    if (DIV < 2) begin : g_div_check
        $error("uart_os_tick: DIV must be at least 2");
    end

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Divider counter and registered tick pulse.
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (!i_en) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (cnt_r == CW'(DIV - 1)) begin
            cnt_r  <= '0;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + 1'b1;
            tick_r <= 1'b0;
        end
    end

    assign o_tick = tick_r;

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling UART receiver with majority vote, false-start rejection,
// optional parity, 1/2 stop bits and a 1-deep valid/ready holding register.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_FRE     = 500,
    parameter int BAUD_RATE   = 9600,
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_ON   = 0,
    parameter int PARITY_TYPE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                  i_clk_sys,
    input  logic                  i_rst_n,
    input  logic                  i_uart_rx,
    output logic [DATA_WIDTH-1:0] o_uart_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_parity_err,
    output logic                  o_frame_err,
    output logic                  o_break,
    output logic                  o_overrun,
    output logic                  o_busy
);

    localparam int   DIV      = calc_div(CLK_FRE, BAUD_RATE);
    localparam int   BW       = $clog2(DATA_WIDTH + 1);
    localparam logic PAR_SENSE = (PARITY_TYPE != 0) ? PARITY_ODD : PARITY_EVEN;

    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_width_check
        $error("uart_rx_os: DATA_WIDTH must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
        $error("uart_rx_os: STOP_BITS must be 1 or 2");
    end

    logic                  rx_meta_r, rx_sync_r, rx_prev_r;
    uart_state_e           state_r, state_next_s;
    logic                  tick_s;
    logic [3:0]            os_cnt_r;
    logic [1:0]            samp_r;
    logic [BW-1:0]         bit_cnt_r;
    logic                  stop_cnt_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic                  par_acc_r, perr_r, ferr_r;
    logic                  bit_s, mid_s, end_s, commit_s, ferr_final_s;

    logic [DATA_WIDTH-1:0] data_r;
    logic                  valid_r, perr_out_r, ferr_out_r, brk_r, ovr_r, busy_r;

    uart_os_tick #(.DIV(DIV)) u_tick (
        .i_clk_sys (i_clk_sys),
        .i_rst_n   (i_rst_n),
        .i_en      (state_r != ST_IDLE),
        .o_tick    (tick_s)
    );

    assign bit_s        = maj3(samp_r[1], samp_r[0], rx_sync_r);
    assign mid_s        = tick_s && (os_cnt_r == OS_SAMPLE_C);
    assign end_s        = tick_s && (os_cnt_r == OS_LAST);
    // The last stop bit's verdict arrives in the commit cycle itself.
    assign ferr_final_s = ferr_r | ~bit_s;

    // Two-flop line synchronizer plus previous sample for start-edge detection.
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= i_uart_rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and commit decode.
    always_comb begin
        state_next_s = state_r;
        commit_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rx_prev_r && !rx_sync_r) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (mid_s && bit_s) begin
                    state_next_s = ST_IDLE;
                end else if (end_s) begin
                    state_next_s = ST_DATA;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (end_s && (bit_cnt_r == BW'(DATA_WIDTH))) begin
                    state_next_s = (PARITY_ON != 0) ? ST_PARITY : ST_STOP;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (end_s) begin
                    state_next_s = ST_STOP;
                end else begin
                    state_next_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                // Leave half a bit early so the next start edge is never missed.
                if (mid_s && (stop_cnt_r == 1'(STOP_BITS - 1))) begin
                    commit_s     = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Bit timing, sample capture and frame accumulation.
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            os_cnt_r   <= 4'd0;
            samp_r     <= 2'b11;
            bit_cnt_r  <= '0;
            stop_cnt_r <= 1'b0;
            shift_r    <= '0;
            par_acc_r  <= 1'b0;
            perr_r     <= 1'b0;
            ferr_r     <= 1'b0;
        end else begin
            if (state_r == ST_IDLE) begin
                os_cnt_r <= 4'd0;
            end else if (tick_s) begin
                os_cnt_r <= os_cnt_r + 4'd1;
            end
            if (tick_s && (os_cnt_r == OS_SAMPLE_A || os_cnt_r == OS_SAMPLE_B)) begin
                samp_r <= {samp_r[0], rx_sync_r};
            end
            case (state_r)
                ST_IDLE: begin
                    bit_cnt_r  <= '0;
                    stop_cnt_r <= 1'b0;
                    par_acc_r  <= 1'b0;
                    perr_r     <= 1'b0;
                    ferr_r     <= 1'b0;
                end
                ST_DATA: begin
                    if (mid_s) begin
                        shift_r   <= {bit_s, shift_r[DATA_WIDTH-1:1]};
                        par_acc_r <= par_acc_r ^ bit_s;
                        bit_cnt_r <= bit_cnt_r + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (mid_s) begin
                        perr_r <= ((par_acc_r ^ bit_s) != PAR_SENSE);
                    end
                end
                ST_STOP: begin
                    if (mid_s && !bit_s) begin
                        ferr_r <= 1'b1;
                    end
                    if (end_s) begin
                        stop_cnt_r <= 1'b1;
                    end
                end
                default: begin
                    bit_cnt_r <= bit_cnt_r;
                end
            endcase
        end
    end

    // Holding register with valid/ready handshake and overrun pulse.
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_r     <= '0;
            valid_r    <= 1'b0;
            perr_out_r <= 1'b0;
            ferr_out_r <= 1'b0;
            brk_r      <= 1'b0;
            ovr_r      <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            busy_r <= (state_next_s != ST_IDLE);
            if (commit_s) begin
                if (!valid_r || i_ready) begin
                    data_r     <= shift_r;
                    perr_out_r <= perr_r;
                    ferr_out_r <= ferr_final_s;
                    brk_r      <= (shift_r == '0) && ferr_final_s;
                    valid_r    <= 1'b1;
                    ovr_r      <= 1'b0;
                end else begin
                    ovr_r <= 1'b1;
                end
            end else begin
                ovr_r <= 1'b0;
                if (valid_r && i_ready) begin
                    valid_r <= 1'b0;
                end
            end
        end
    end

    assign o_uart_data  = data_r;
    assign o_valid      = valid_r;
    assign o_parity_err = perr_out_r;
    assign o_frame_err  = ferr_out_r;
    assign o_break      = brk_r;
    assign o_overrun    = ovr_r;
    assign o_busy       = busy_r;

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: three receivers (8N1, 8E1, 8N2) at 50 MHz / 115200 baud,
// directed frames plus randomized traffic checked against a frame-level model.
module tb_uart_rx_os;

    localparam int BIT = 432;

    typedef struct {
        int         inst;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } exp_t;

    logic       clk, rst_n, rand_mode;
    logic       rx    [3];
    logic       ready [3];
    logic [7:0] dout  [3];
    logic       valid [3], perr [3], ferr [3], brk [3], ovr [3], busy [3];

    exp_t exp_q[$];
    int   nchk, nerr, cyc;
    int   ovr_cnt [3], exp_ovr [3], busy_cnt [3], vcyc [3], hs_cnt [3];
    int   rise_cyc [3], start_cyc [3];
    logic hold [3], was_valid [3];
    logic [7:0] hd [3];
    logic [2:0] hf [3];
    logic [7:0] last_data [3];
    logic [2:0] last_flags [3];

    uart_rx_os #(.CLK_FRE(50), .BAUD_RATE(115200), .PARITY_ON(0), .STOP_BITS(1)) u0 (
        .i_clk_sys(clk), .i_rst_n(rst_n), .i_uart_rx(rx[0]), .o_uart_data(dout[0]),
        .o_valid(valid[0]), .i_ready(ready[0]), .o_parity_err(perr[0]), .o_frame_err(ferr[0]),
        .o_break(brk[0]), .o_overrun(ovr[0]), .o_busy(busy[0]));
    uart_rx_os #(.CLK_FRE(50), .BAUD_RATE(115200), .PARITY_ON(1), .PARITY_TYPE(0), .STOP_BITS(1)) u1 (
        .i_clk_sys(clk), .i_rst_n(rst_n), .i_uart_rx(rx[1]), .o_uart_data(dout[1]),
        .o_valid(valid[1]), .i_ready(ready[1]), .o_parity_err(perr[1]), .o_frame_err(ferr[1]),
        .o_break(brk[1]), .o_overrun(ovr[1]), .o_busy(busy[1]));
    uart_rx_os #(.CLK_FRE(50), .BAUD_RATE(115200), .PARITY_ON(0), .STOP_BITS(2)) u2 (
        .i_clk_sys(clk), .i_rst_n(rst_n), .i_uart_rx(rx[2]), .o_uart_data(dout[2]),
        .o_valid(valid[2]), .i_ready(ready[2]), .o_parity_err(perr[2]), .o_frame_err(ferr[2]),
        .o_break(brk[2]), .o_overrun(ovr[2]), .o_busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare process: reset values, hold stability and every delivered word.
    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                nchk++;
                if (dout[i] != 8'h00 || valid[i] || perr[i] || ferr[i] || brk[i] || ovr[i] || busy[i]) begin
                    nerr++;
                    $display("FAIL reset_outputs inst=%0d got data=%h v=%b p=%b f=%b b=%b o=%b busy=%b want all 0",
                             i, dout[i], valid[i], perr[i], ferr[i], brk[i], ovr[i], busy[i]);
                end
                hold[i] = 1'b0;
            end else begin
                if (ovr[i])  ovr_cnt[i]++;
                if (busy[i]) busy_cnt[i]++;
                if (valid[i]) vcyc[i]++;
                if (valid[i] && !was_valid[i]) rise_cyc[i] = cyc;
                if (hold[i]) begin
                    nchk++;
                    if (!valid[i] || dout[i] != hd[i] || {perr[i], ferr[i], brk[i]} != hf[i]) begin
                        nerr++;
                        $display("FAIL hold_stable inst=%0d got v=%b data=%h flags=%b want v=1 data=%h flags=%b",
                                 i, valid[i], dout[i], {perr[i], ferr[i], brk[i]}, hd[i], hf[i]);
                    end
                end
                if (valid[i] && ready[i]) begin
                    int idx;
                    idx = -1;
                    foreach (exp_q[j]) if (idx < 0 && exp_q[j].inst == i) idx = j;
                    nchk++;
                    if (idx < 0) begin
                        nerr++;
                        $display("FAIL unexpected_word inst=%0d got data=%h want no word", i, dout[i]);
                    end else begin
                        if (dout[i] != exp_q[idx].data ||
                            {perr[i], ferr[i], brk[i]} != {exp_q[idx].perr, exp_q[idx].ferr, exp_q[idx].brk}) begin
                            nerr++;
                            $display("FAIL word inst=%0d got data=%h pfb=%b want data=%h pfb=%b", i, dout[i],
                                     {perr[i], ferr[i], brk[i]}, exp_q[idx].data,
                                     {exp_q[idx].perr, exp_q[idx].ferr, exp_q[idx].brk});
                        end
                        exp_q.delete(idx);
                    end
                    last_data[i]  = dout[i];
                    last_flags[i] = {perr[i], ferr[i], brk[i]};
                    hs_cnt[i]++;
                end
                hold[i] = valid[i] && !ready[i];
                hd[i]   = dout[i];
                hf[i]   = {perr[i], ferr[i], brk[i]};
            end
            was_valid[i] = valid[i];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic drive_line(input int inst, input logic v, input int n);
        rx[inst] = v;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            if (rand_mode) ready[inst] = 1'($urandom_range(0, 1));
        end
    endtask

    // Model: the expected word follows from the bits put on the line.
    task automatic send_frame(input int inst, input logic [7:0] d, input logic pbit,
                              input logic s1, input logic s2);
        logic par_on;
        int   nstop, pending;
        exp_t e;
        par_on  = (inst == 1);
        nstop   = (inst == 2) ? 2 : 1;
        pending = 0;
        foreach (exp_q[j]) if (exp_q[j].inst == inst) pending++;
        e.inst = inst;
        e.data = d;
        e.perr = par_on && ((($countones(d) + int'(pbit)) % 2) != 0);
        e.ferr = !s1 || (nstop == 2 && !s2);
        e.brk  = (d == 8'h00) && e.ferr;
        if (!rand_mode && !ready[inst] && pending > 0) exp_ovr[inst]++;
        else exp_q.push_back(e);
        start_cyc[inst] = cyc;
        drive_line(inst, 1'b0, BIT);
        for (int b = 0; b < 8; b++) drive_line(inst, d[b], BIT);
        if (par_on) drive_line(inst, pbit, BIT);
        drive_line(inst, s1, BIT);
        if (nstop == 2) drive_line(inst, s2, BIT);
        drive_line(inst, 1'b1, 0);
    endtask

    task automatic rand_run(input int inst, input int n);
        logic [7:0] d;
        for (int k = 0; k < n; k++) begin
            drive_line(inst, 1'b1, $urandom_range(0, 300));
            d = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) d = 8'h00;
            send_frame(inst, d, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0),
                       ($urandom_range(0, 4) != 0));
        end
    endtask

    initial begin
        int s_v, s_hs, s_ov, s_busy;
        nchk = 0; nerr = 0; cyc = 0; rand_mode = 1'b0; rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rx[i] = 1'b1; ready[i] = 1'b1; ovr_cnt[i] = 0; exp_ovr[i] = 0; busy_cnt[i] = 0;
            vcyc[i] = 0; hs_cnt[i] = 0; rise_cyc[i] = 0; start_cyc[i] = 0; hold[i] = 1'b0;
            was_valid[i] = 1'b0; last_data[i] = 8'h00; last_flags[i] = 3'b000;
        end
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_line(0, 1'b1, 20);

        // 8N1 0xA5: one-cycle valid, clean flags, latency about 9.5 bits plus sampling offset.
        s_v = vcyc[0];
        send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1);
        drive_line(0, 1'b1, 10);
        check("a5_data", last_data[0], 8'hA5);
        check("a5_flags", last_flags[0], 3'b000);
        check("a5_valid_cycles", vcyc[0] - s_v, 1);
        check("a5_latency", ((rise_cyc[0] - start_cyc[0]) >= 4150) && ((rise_cyc[0] - start_cyc[0]) <= 4175), 1);

        // Glitch shorter than the first sample point is rejected.
        s_hs = hs_cnt[0]; s_busy = busy_cnt[0];
        drive_line(0, 1'b0, 100);
        drive_line(0, 1'b1, 16 * 27);
        check("glitch_busy_low", busy[0], 1'b0);
        check("glitch_busy_seen", busy_cnt[0] > s_busy, 1);
        check("glitch_no_word", hs_cnt[0] - s_hs, 0);

        // Even parity on 0x3C (four ones): parity bit 1 is wrong, 0 is right.
        send_frame(1, 8'h3C, 1'b1, 1'b1, 1'b1);
        drive_line(1, 1'b1, 10);
        check("par_bad_data", last_data[1], 8'h3C);
        check("par_bad_flags", last_flags[1], 3'b100);
        send_frame(1, 8'h3C, 1'b0, 1'b1, 1'b1);
        drive_line(1, 1'b1, 10);
        check("par_good_flags", last_flags[1], 3'b000);

        // Break, and a framing error on the second of two stop bits.
        send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1);
        drive_line(0, 1'b1, 10);
        check("break_flags", last_flags[0], 3'b011);
        send_frame(2, 8'h81, 1'b0, 1'b1, 1'b0);
        drive_line(2, 1'b1, 10);
        check("stop2_data", last_data[2], 8'h81);
        check("stop2_flags", last_flags[2], 3'b010);

        // Overrun: consumer stalled across two back-to-back frames.
        ready[0] = 1'b0;
        s_ov = ovr_cnt[0];
        send_frame(0, 8'h11, 1'b0, 1'b1, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1);
        drive_line(0, 1'b1, 5);
        check("ovr_held_valid", valid[0], 1'b1);
        check("ovr_held_data", dout[0], 8'h11);
        check("ovr_pulses", ovr_cnt[0] - s_ov, 1);
        s_hs = hs_cnt[0];
        ready[0] = 1'b1;
        drive_line(0, 1'b1, 3);
        check("ovr_one_handshake", hs_cnt[0] - s_hs, 1);
        check("ovr_valid_drops", valid[0], 1'b0);
        check("ovr_consumed_data", last_data[0], 8'h11);

        // Reset in the middle of a frame, then a clean frame.
        drive_line(0, 1'b0, BIT);
        drive_line(0, 1'b1, BIT);
        drive_line(0, 1'b0, 200);
        rst_n = 1'b0;
        rx[0] = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("rst_valid", valid[0], 1'b0);
        check("rst_busy", busy[0], 1'b0);
        rst_n = 1'b1;
        drive_line(0, 1'b1, 500);
        check("post_rst_idle", busy[0], 1'b0);
        send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b1);
        drive_line(0, 1'b1, 10);
        check("post_rst_data", last_data[0], 8'h5A);
        check("post_rst_flags", last_flags[0], 3'b000);

        // Randomized traffic on all three receivers with a randomly stalling consumer.
        rand_mode = 1'b1;
        fork
            rand_run(0, 5);
            rand_run(1, 5);
            rand_run(2, 5);
        join
        rand_mode = 1'b0;
        for (int i = 0; i < 3; i++) ready[i] = 1'b1;
        repeat (50) begin @(posedge clk); #1; end
        check("all_words_delivered", exp_q.size(), 0);
        for (int i = 0; i < 3; i++) check("overrun_count", ovr_cnt[i], exp_ovr[i]);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Second-generation UART receiver that replaces the single-mid-bit-sample receiver.
- Uses 16x oversampling with a 3-sample majority vote, rejects false start bits, and supports 1 or 2 stop bits and optional even/odd parity.
- Reports parity, framing, break and overrun status.
- Delivers each received word through a 1-deep holding register with a valid/ready handshake, so downstream logic (CPU I/O bridge) can stall without losing the frame already held.

Parameters:
- CLK_FRE, 500, system clock in MHz.
- BAUD_RATE, 9600, line baud rate.
- DATA_WIDTH, 8, data bits per frame; legal range 5..9.
- PARITY_ON, 0, 1 = parity bit present.
- PARITY_TYPE, 0, 0 = even, 1 = odd.
- STOP_BITS, 1, legal values 1 or 2.

Ports:
- i_clk_sys  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_uart_rx  in  1  asynchronous serial line, idles high.
- o_uart_data  out  DATA_WIDTH  held received word.
- o_valid  out  1  o_uart_data and the flags are valid.
- i_ready  in  1  consumer accepts the held word.
- o_parity_err  out  1  parity mismatch for the held word.
- o_frame_err  out  1  a stop bit sampled low for the held word.
- o_break  out  1  held word is all-zero with o_frame_err set.
- o_overrun  out  1  one-cycle pulse: a frame was dropped because the holder was full.
- o_busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clock/reset: one clock, i_clk_sys. Reset i_rst_n is asynchronous, active-low.
- Reset values: all outputs 0; line synchronizer and previous-sample flop set to 1; FSM in IDLE; all counters 0.
- Input sync: 2-flop synchronizer on i_uart_rx. All logic uses the synchronized value rx_s.
- Tick generator:
  - DIV = CLK_FRE*1000000/(BAUD_RATE*16), integer-truncated.
  - Elaboration fails if DIV < 2.
  - 1-cycle tick pulse every DIV cycles.
  - Counter held at 0 while in IDLE.
- Bit timing:
  - os_cnt (4 bits) increments on each tick.
  - rx_s is sampled at os_cnt 7, 8 and 9; the bit value is the majority of the three and is resolved on the tick where os_cnt = 9.
  - The bit period ends on the tick where os_cnt wraps 15 -> 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on a falling edge of rx_s (previous 1, current 0). os_cnt and the tick counter restart from 0.
  - START: if the resolved bit is 1, this is a false start: go to IDLE, no output, no flags. If 0, go to DATA at the end of the bit.
  - DATA: shift in DATA_WIDTH bits LSB first and accumulate XOR parity. After the last bit, go to PARITY if PARITY_ON, else STOP.
  - PARITY: parity error = (data XOR-reduce ^ parity bit) != PARITY_TYPE.
  - STOP: each stop bit is resolved at os_cnt 9; a 0 sets the frame error.
    - After the resolution of the last stop bit, commit and go to IDLE immediately, half a bit early, so the FSM resynchronises to the next start edge.
    - With STOP_BITS = 2, the first stop bit runs a full period; only the second ends early.
- Commit (single cycle):
  - If o_valid=0, or o_valid=1 with i_ready=1 in the same cycle: load o_uart_data and all three flags, and set o_valid=1.
  - Else: drop the new frame, keep the held word and flags unchanged, and pulse o_overrun for 1 cycle.
- Handshake:
  - A word is consumed on a cycle with o_valid & i_ready. o_valid falls the next cycle unless a commit happens in that same cycle.
  - o_uart_data and the flags are stable while o_valid=1 and i_ready=0.
  - Frames with parity or framing errors are still delivered, with their flags set.
- o_break = (received data == 0) & frame error, registered with the commit.
- Latency: o_valid rises 1 cycle after the tick that resolves the last stop bit.
- A line held low after a break does not start a new frame until rx_s returns high and falls again.

Decomposition:
- Shared package uart_pkg:
  - FSM state encodings: IDLE, START, DATA, PARITY, STOP.
  - PARITY_EVEN / PARITY_ODD constants.
  - OS_RATE=16 and sample indices 7/8/9.
  - Divisor computation function.
- One sub-module: uart_os_tick (parameter DIV; inputs i_clk_sys, i_rst_n, i_en; output o_tick). It is reused later by the transmitter.

Test Plan:
- Bench setting: CLK_FRE=50, BAUD_RATE=115200, so DIV=27 and one bit = 432 cycles.
- 8N1, send 0xA5, i_ready=1 -> one-cycle o_valid with o_uart_data=0xA5; parity_err=frame_err=break=0.
- Line glitch low for 100 cycles (less than 7*27), then high -> no o_valid; o_busy returns to 0 within 16*27 cycles.
- PARITY_ON=1, PARITY_TYPE=0, send 0x3C with parity bit 1 -> o_uart_data=0x3C, o_parity_err=1; the same frame with parity bit 0 -> o_parity_err=0.
- Send 0x00 with stop bit 0 -> o_frame_err=1, o_break=1. STOP_BITS=2 with only the second stop bit low -> o_frame_err=1.
- i_ready=0, send 0x11 then 0x22 back-to-back -> o_uart_data stays 0x11 and o_overrun pulses exactly once. Raising i_ready then gives one handshake, and o_valid drops.
- Assert i_rst_n=0 for 3 cycles mid-DATA of a frame, then send 0x5A -> all outputs 0 during reset, no spurious word, then o_uart_data=0x5A with no flags.
